// File: rtl/conv_pkg.sv
// Shared types and the output post-processing for the 1x1 expand engine.
// CONV1X1_RELU_EN selects ReLU clamping of the biased sum before shift/saturate.
package conv_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT, S_DONE} state_t;

  // Widest accumulator container; lanes hold 2*WIDTH bits and sign-extend into it.
  typedef logic signed [63:0] acc_t;

  function automatic acc_t post_sat(input acc_t s, input int frac, input int width);
    acc_t v, hi, lo;
    v = s;
`ifdef CONV1X1_RELU_EN
    if (v[63]) v = '0;
`endif
    v  = v >>> frac;
    hi = (acc_t'(1) <<< (width - 1)) - acc_t'(1);
    lo = -hi - acc_t'(1);
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One output-channel MAC lane: signed multiply, wrapping accumulate, clear.
module conv_mac_lane #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   w,
  output logic [2*WIDTH-1:0] acc
);
  logic signed [2*WIDTH-1:0] xs, ws, prod;

  assign xs   = {{WIDTH{x[WIDTH-1]}}, x};
  assign ws   = {{WIDTH{w[WIDTH-1]}}, w};
  assign prod = xs * ws;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + prod;
  end
endmodule

// File: rtl/conv1x1_expand_engine.sv
// 1x1 convolution expand engine: CHIN beats per pixel into CHOUT MAC lanes.
// Build option CONV1X1_RELU_EN (see conv_pkg) adds ReLU to the output stage.
module conv1x1_expand_engine
  import conv_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CHIN    = 32,
  parameter int CHOUT   = 128,
  parameter int WOUT    = 32,
  parameter int FRAC    = 14,
  parameter int NLAYERS = 2,
  localparam int LW     = (NLAYERS > 1) ? $clog2(NLAYERS) : 1,
  localparam int AW     = (CHIN > 1) ? $clog2(CHIN) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LW-1:0]              layer_sel,
  output logic [LW-1:0]              layer_id,
  input  logic                       ifm_valid,
  output logic                       ifm_ready,
  input  logic [WIDTH-1:0]           ifm,
  output logic [AW-1:0]              w_addr,
  input  logic [CHOUT*WIDTH-1:0]     w_data,
  input  logic [CHOUT*2*WIDTH-1:0]   bias,
  output logic [CHOUT*WIDTH-1:0]     ofm,
  output logic                       ofm_valid,
  output logic                       busy,
  output logic                       done
);
  localparam int NPIX = WOUT * WOUT;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  state_t                          state;
  logic [PW-1:0]                   pix;
  logic                            beat, clr;
  logic [CHOUT-1:0][2*WIDTH-1:0]   acc;
  logic [CHOUT-1:0][WIDTH-1:0]     ofm_next, ofm_q;

  assign ifm_ready = (state == S_ACCUM);
  assign busy      = (state != S_IDLE);
  assign beat      = ifm_valid && ifm_ready;
  assign clr       = (state == S_OUT);
  assign ofm       = ofm_q;

  for (genvar c = 0; c < CHOUT; c++) begin : g_lane
    logic signed [2*WIDTH-1:0] sum;

    conv_mac_lane #(.WIDTH(WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (beat),
      .clr (clr),
      .x   (ifm),
      .w   (w_data[c*WIDTH +: WIDTH]),
      .acc (acc[c])
    );

    // Bias add wraps at 2*WIDTH like the accumulator itself.
    assign sum         = acc[c] + bias[c*2*WIDTH +: 2*WIDTH];
    assign ofm_next[c] = WIDTH'(post_sat(acc_t'(sum), FRAC, WIDTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      w_addr    <= '0;
      pix       <= '0;
      layer_id  <= '0;
      ofm_q     <= '0;
      ofm_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      ofm_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          layer_id <= layer_sel;
          w_addr   <= '0;
          pix      <= '0;
          state    <= S_ACCUM;
        end
        S_ACCUM: if (beat) begin
          if (w_addr == AW'(CHIN - 1)) begin
            w_addr <= '0;
            state  <= S_OUT;
          end else begin
            w_addr <= w_addr + 1'b1;
          end
        end
        S_OUT: begin
          ofm_q     <= ofm_next;
          ofm_valid <= 1'b1;
          w_addr    <= '0;
          if (pix == PW'(NPIX - 1)) begin
            pix   <= '0;
            state <= S_DONE;
          end else begin
            pix   <= pix + 1'b1;
            state <= S_ACCUM;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1x1_expand_engine.sv
// Scoreboard bench for conv1x1_expand_engine at CHIN=4, CHOUT=4, WOUT=2.
module tb_conv1x1_expand_engine;
  localparam int W = 16, CI = 4, CO = 4, WO = 2, FR = 14, NL = 2;

  logic              clk = 0, rst = 1, start = 0, ifm_valid = 0;
  logic [0:0]        layer_sel = '0, layer_id;
  logic              ifm_ready, ofm_valid, busy, done;
  logic [W-1:0]      ifm = '0;
  logic [1:0]        w_addr;
  logic [CO*W-1:0]   w_data, ofm;
  logic [CO*2*W-1:0] bias;

  logic signed [15:0] wt [0:1][0:3][0:3];
  logic signed [31:0] bs [0:1][0:3];
  logic [63:0]        exp_q[$];
  int checks = 0, errors = 0, vcnt = 0, dcnt = 0, cyc = 0, last_acc = 0, cur_layer = 0;

  conv1x1_expand_engine #(.WIDTH(W), .CHIN(CI), .CHOUT(CO), .WOUT(WO), .FRAC(FR), .NLAYERS(NL)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel), .layer_id(layer_id),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm(ifm), .w_addr(w_addr),
    .w_data(w_data), .bias(bias), .ofm(ofm), .ofm_valid(ofm_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    w_data = '0;
    bias   = '0;
    for (int c = 0; c < CO; c++) begin
      w_data[c*W +: W]     = wt[layer_id][w_addr][c];
      bias[c*2*W +: 2*W]   = bs[layer_id][c];
    end
  end

  always @(posedge clk) begin
    if (ifm_valid && ifm_ready) last_acc <= cyc;
    cyc <= cyc + 1;
  end

  // Output monitor: every ofm_valid pops one expected pixel and checks latency.
  always @(negedge clk) begin
    if (!rst && ofm_valid) begin
      logic [63:0] e;
      vcnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ofm_valid got %h required no output", ofm);
      end else begin
        e = exp_q.pop_front();
        if (ofm !== e) begin
          errors++;
          $display("FAIL ofm_pixel got %h required %h", ofm, e);
        end
      end
      checks++;
      if (cyc - last_acc != 2) begin
        errors++;
        $display("FAIL ofm_latency got %0d required 2", cyc - last_acc);
      end
    end
    if (!rst && done) dcnt++;
  end

  function automatic logic [15:0] ref_post(input logic signed [31:0] s);
    longint v;
    v = s;
`ifdef CONV1X1_RELU_EN
    if (v < 0) v = 0;
`endif
    v = v >>> 14;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic set_layer(input int l, input logic signed [15:0] wv, input int bshift);
    for (int a = 0; a < CI; a++)
      for (int c = 0; c < CO; c++) wt[l][a][c] = wv;
    for (int c = 0; c < CO; c++) bs[l][c] = (bshift >= 0) ? (32'(c) << bshift) : 32'sd0;
  endtask

  task automatic start_run(input int l);
    @(negedge clk);
    layer_sel = 1'(l); start = 1; cur_layer = l;
    @(negedge clk);
    start = 0;
  endtask

  task automatic send_beat(input logic [15:0] v);
    int n = 0;
    ifm = v; ifm_valid = 1;
    while (!ifm_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      errors++;
      $display("FAIL beat_timeout got ifm_ready=0 required 1");
    end
    @(negedge clk);
    ifm_valid = 0;
  endtask

  task automatic run_pixel(input logic signed [15:0] px [4], input int gapmax);
    logic [63:0] e;
    logic signed [31:0] a;
    for (int c = 0; c < CO; c++) begin
      a = 0;
      for (int b = 0; b < CI; b++) a = a + 32'(px[b]) * 32'(wt[cur_layer][b][c]);
      e[c*16 +: 16] = ref_post(a + bs[cur_layer][c]);
    end
    exp_q.push_back(e);
    for (int b = 0; b < CI; b++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      send_beat(px[b]);
    end
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (dcnt == d0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (dcnt != d0 + 1) begin
      errors++;
      $display("FAIL done_pulse got %0d required 1", dcnt - d0);
    end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_after_done got busy=%b pending=%0d required busy=0 pending=0", busy, exp_q.size());
    end
  endtask

  task automatic run_uniform(input int l, input logic signed [15:0] v, input int gapmax);
    logic signed [15:0] px [4];
    int d0 = dcnt;
    for (int b = 0; b < 4; b++) px[b] = v;
    start_run(l);
    for (int p = 0; p < WO*WO; p++) run_pixel(px, gapmax);
    wait_done(d0);
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (ofm !== '0 || ofm_valid !== 0 || done !== 0 || busy !== 0 || ifm_ready !== 0 ||
        layer_id !== '0 || w_addr !== '0) begin
      errors++;
      $display("FAIL %s got ofm=%h v=%b d=%b busy=%b rdy=%b lid=%b wa=%0d required all 0",
               tag, ofm, ofm_valid, done, busy, ifm_ready, layer_id, w_addr);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 0;
    repeat (3) @(negedge clk);
    check_zero_outputs("post_reset_idle");
  endtask

  task automatic test_saturate;
    set_layer(0, 16'sd16384, -1);
    run_uniform(0, 16'sd16384, 0);
    checks++;
    if (ofm !== {4{16'h7fff}}) begin
      errors++;
      $display("FAIL sat_pos got %h required %h", ofm, {4{16'h7fff}});
    end
  endtask

  task automatic test_reset_mid;
    int v0 = vcnt, d0 = dcnt;
    start_run(0);
    send_beat(16'sd16384);
    send_beat(16'sd16384);
    checks++;
    if (w_addr !== 2'd2 || busy !== 1) begin
      errors++;
      $display("FAIL mid_accum got w_addr=%0d busy=%b required 2 1", w_addr, busy);
    end
    #1 rst = 1;
    #1 check_zero_outputs("reset_mid_accum");
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (vcnt != v0 || dcnt != d0 || busy !== 0) begin
      errors++;
      $display("FAIL reset_discard got valid=%0d done=%0d busy=%b required 0 0 0", vcnt - v0, dcnt - d0, busy);
    end
  endtask

  task automatic test_negative;
    logic [15:0] want;
`ifdef CONV1X1_RELU_EN
    want = 16'h0000;
`else
    want = 16'h8000;
`endif
    set_layer(0, -16'sd8192, -1);
    run_uniform(0, 16'sd16384, 1);
    checks++;
    if (ofm !== {4{want}}) begin
      errors++;
      $display("FAIL sat_neg got %h required %h", ofm, {4{want}});
    end
  endtask

  task automatic test_gaps;
    logic signed [15:0] px [4];
    int v0 = vcnt, d0 = dcnt;
    for (int a = 0; a < CI; a++)
      for (int c = 0; c < CO; c++) wt[0][a][c] = 16'($urandom_range(0, 65535));
    for (int c = 0; c < CO; c++) bs[0][c] = 32'($urandom);
    start_run(0);
    for (int p = 0; p < WO*WO; p++) begin
      for (int b = 0; b < 4; b++) px[b] = 16'($urandom_range(0, 65535));
      run_pixel(px, 4);
    end
    wait_done(d0);
    checks++;
    if (vcnt - v0 != 4) begin
      errors++;
      $display("FAIL gap_pixels got %0d required 4", vcnt - v0);
    end
  endtask

  task automatic test_layer_sel;
    logic signed [15:0] px [4];
    int d0 = dcnt;
    set_layer(0, 16'sd100, -1);
    set_layer(1, 16'sd3000, 10);
    start_run(1);
    for (int p = 0; p < WO*WO; p++) begin
      for (int b = 0; b < 4; b++) px[b] = 16'(1000 * (p + 1) + b);
      run_pixel(px, 1);
      if (p == 0) begin
        layer_sel = 1'b0; start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (layer_id !== 1'b1) begin
          errors++;
          $display("FAIL layer_hold got %b required 1", layer_id);
        end
      end
    end
    wait_done(d0);
  endtask

  task automatic test_bias;
    set_layer(0, 16'sd0, 14);
    run_uniform(0, 16'sd12345, 0);
    for (int c = 0; c < CO; c++) begin
      checks++;
      if (ofm[c*16 +: 16] !== 16'(c)) begin
        errors++;
        $display("FAIL bias_ch%0d got %0d required %0d", c, ofm[c*16 +: 16], c);
      end
    end
  endtask

  initial begin
    set_layer(0, 16'sd0, -1);
    set_layer(1, 16'sd0, -1);
    test_reset;
    test_saturate;
    test_reset_mid;
    test_negative;
    test_gaps;
    test_layer_sel;
    test_bias;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
